keccak_gather: RTL and testbench
================================

# keccak_gather

Word collector directly upstream of the 512-bit block path toward the Keccak core: accepts 32-bit words from the custom-instruction port, assembles them into a 512-bit message block, and hands complete blocks to `keccak_ctrl` via valid/ready. Mirrors the 512-to-32 readout path in reverse and uses the same 6-bit `num` immediate format. Optional Keccak pad10*1 insertion at word granularity closes the final block.

## Interface
- No parameters. Block width is fixed at 512 bits: 16 words of 32 bits.
- `clk` in 1 — single clock; all state changes on its rising edge.
- `reset` in 1 — asynchronous, active-low; clears all state.
- `en` in 1 — write strobe from the CPU custom instruction.
- `num` in 6 — custom-instruction immediate (`cust5_limm`):
  - `[3:0]` word index; word i occupies `out512[32i+31:32i]`.
  - `[4]` last word of the message.
  - `[5]` clear.
- `in32` in 32 — write data.
- `out512` out 512 — block to `keccak_ctrl`. Registered; always equals the internal buffer.
- `out_valid` out 1 — block on `out512` is complete.
- `out_last` out 1 — block is the final block of the message; meaningful only while `out_valid` is high.
- `out_ready` in 1 — `keccak_ctrl` accepts the block.
- `stall` out 1 — collector is not accepting writes; the CPU holds the instruction.

## Operation
- State: 512-bit buffer `buf`, 16-bit `mask` of written words, `pad_pending` flag, FSM {FILL, SEND, PAD}. PAD exists only with the macro.
- FILL (`stall`=0, `out_valid`=0):
  - `en & num[5]`: clear `buf` and `mask`, remain in FILL. Clear wins over any write in the same cycle; that write is discarded.
  - `en & !num[5]`: `buf[idx] <= in32`, `mask[idx] <= 1`. Rewriting an already-written index overwrites the word; `mask` is unchanged.
  - Block completes when the post-write `mask` equals 16'hFFFF, or when `num[4]` = 1. On completion go to SEND; `out_last` <= `num[4]`.
  - When `num[4]` closes a partial block, unwritten words stay 0.
- SEND (`stall`=1, `out_valid`=1):
  - `en` is ignored.
  - On `out_ready`: clear `buf`, `mask` and `out_last`. Then go to PAD if `pad_pending`, otherwise to FILL.
- PAD (macro only; `stall`=1, `out_valid`=1, `out_last`=1):
  - `buf` holds the pad block: word0 = 32'h00000001, word15 = 32'h80000000, all other words 0.
  - On `out_ready`: clear `buf`, go to FILL.
- `out_ready` in FILL is ignored.

## Timing
- Reset values: `out512` = 0, `out_valid` = 0, `out_last` = 0, `stall` = 0; FSM = FILL; `mask` = 0; `pad_pending` = 0.
- A completing write at edge N gives `out_valid` = 1 and `stall` = 1 after edge N, i.e. visible in cycle N+1.
- Handshake completes at the edge where `out_valid & out_ready`. After that edge:
  - next state FILL: `out_valid` = 0 and `stall` = 0, so a new write is accepted in the following cycle.
  - next state PAD: `out_valid` remains 1 with no gap.
- `out512`, `out_valid` and `out_last` are stable while `out_valid` = 1 and `out_ready` = 0.
- Throughput: at most one block per 17 cycles (16 writes plus 1 handshake cycle) when `out_ready` is tied high.
- Asserting `reset` in SEND or PAD drops the pending block immediately; no handshake occurs.

## Configuration
- `KECCAK_GATHER_PAD_EN` defined — on a write with `num[4]` = 1, let k = highest set bit of the post-write `mask` + 1:
  - k < 15: `buf[k] |= 32'h00000001` and `buf[15] |= 32'h80000000`.
  - k = 15: `buf[15] |= 32'h80000001`.
  - k = 16: no in-block padding; the block is sent with `out_last` = 0 and `pad_pending` is set, so the PAD block follows as the final block.
- `KECCAK_GATHER_PAD_EN` undefined — no padding logic and no PAD state; `out_last` = `num[4]`; software pads explicitly.

## Test plan
- Reset, then write 32'h1000_000i to index i for i = 0..15 with `out_ready` = 0:
  - `out_valid` rises in the cycle after the 16th write.
  - `out512[31:0]` = 32'h10000000 and `out512[511:480]` = 32'h1000000F.
  - `stall` = 1 and `out_last` = 0 until `out_ready` is asserted.
- Write 32'hAAAA5555 to index 3 with `num[4]` = 1:
  - macro undefined: words 0–2 and 4–15 are 0, `out_last` = 1.
  - macro defined: word4 = 32'h00000001 and word15 = 32'h80000000.
- Macro defined, 16 words written with the last one carrying `num[4]` = 1, `out_ready` = 1:
  - first block has `out_last` = 0.
  - next cycle the pad block appears with word0 = 32'h00000001, word15 = 32'h80000000 and `out_last` = 1.
- Write indices 0–5, then issue `en` with `num` = 6'b100000:
  - `mask` is cleared and no block is emitted.
  - a subsequent full 16-word fill produces a block containing only the new data.
- Issue `en` writes while in SEND:
  - the write is ignored and `out512` is unchanged.
  - the same write reissued after the handshake lands.
- Assert `reset` low mid-SEND:
  - `out_valid` = 0 immediately and all outputs return to their reset values.

Source files
------------

// File: rtl/keccak_gather.sv
// -----------------------------------------------------------------------------
// keccak_gather
//
// Collects 32-bit words from the CPU custom-instruction port into a 512-bit
// message block (16 words) and hands complete blocks to keccak_ctrl through a
// valid/ready handshake.
//
// Ports:
//   clk        in   1    single clock, rising edge
//   reset      in   1    asynchronous, active-low; clears all state
//   en         in   1    write strobe from the custom instruction
//   num        in   6    immediate: [3:0] word index, [4] last word, [5] clear
//   in32       in   32   write data
//   out512     out  512  block toward keccak_ctrl (word i at [32i+31:32i])
//   out_valid  out  1    out512 holds a complete block
//   out_last   out  1    block is the final block of the message
//   out_ready  in   1    keccak_ctrl accepts the block
//   stall      out  1    collector not accepting writes; CPU holds instruction
//
// Build option:
//   KECCAK_GATHER_PAD_EN  when defined, a write carrying num[4] closes the
//                         message with Keccak pad10*1 at word granularity.
//                         If the final word lands in word 15 with no room left,
//                         an extra pad-only block (PAD state) follows.
// -----------------------------------------------------------------------------
module keccak_gather (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic [5:0]   num,
    input  logic [31:0]  in32,
    output logic [511:0] out512,
    output logic         out_valid,
    output logic         out_last,
    input  logic         out_ready,
    output logic         stall
);

`ifdef KECCAK_GATHER_PAD_EN
    typedef enum logic [1:0] {
        ST_FILL = 2'd0,
        ST_SEND = 2'd1,
        ST_PAD  = 2'd2
    } state_e;

    // Pad-only block: first pad bit in word 0, closing bit in word 15.
    localparam logic [511:0] PAD_BLOCK = {32'h8000_0000, 448'd0, 32'h0000_0001};
`else
    typedef enum logic [1:0] {
        ST_FILL = 2'd0,
        ST_SEND = 2'd1
    } state_e;
`endif

    state_e         state_q, state_d;
    logic [511:0]   buf_q, buf_d;
    logic [15:0]    mask_q, mask_d;
    logic           pad_pending_q, pad_pending_d;
    logic           out_last_q, out_last_d;
    logic           out_valid_q, out_valid_d;
    logic           stall_q, stall_d;

    logic [3:0]     idx_s;
    logic [15:0]    mask_post_s;
    logic           complete_s;
`ifdef KECCAK_GATHER_PAD_EN
    logic [4:0]     pad_pos_s;

    // One past the highest written word: where the first pad bit goes.
    function automatic logic [4:0] next_free_word(input logic [15:0] m);
        logic [4:0] k;
        k = 5'd0;
        for (int i = 0; i < 16; i++) begin
            if (m[i]) begin
                k = 5'(i + 1);
            end else begin
                k = k;
            end
        end
        return k;
    endfunction
`endif

    // Next-state, buffer update and output decode.
    always_comb begin
        state_d       = state_q;
        buf_d         = buf_q;
        mask_d        = mask_q;
        pad_pending_d = pad_pending_q;
        out_last_d    = out_last_q;

        idx_s       = num[3:0];
        mask_post_s = mask_q | (16'd1 << idx_s);
        complete_s  = (mask_post_s == 16'hFFFF) || num[4];
`ifdef KECCAK_GATHER_PAD_EN
        pad_pos_s   = next_free_word(mask_post_s);
`endif

        case (state_q)
            ST_FILL: begin
                if (en) begin
                    if (num[5]) begin
                        // Clear takes priority; the accompanying data is dropped.
                        buf_d  = 512'd0;
                        mask_d = 16'd0;
                    end else begin
                        buf_d[{idx_s, 5'd0} +: 32] = in32;
                        mask_d = mask_post_s;
                        if (complete_s) begin
                            state_d    = ST_SEND;
                            out_last_d = num[4];
`ifdef KECCAK_GATHER_PAD_EN
                            if (num[4]) begin
                                if (pad_pos_s == 5'd16) begin
                                    // Block full: send as-is, pad block follows.
                                    out_last_d    = 1'b0;
                                    pad_pending_d = 1'b1;
                                end else if (pad_pos_s == 5'd15) begin
                                    buf_d[511:480] = buf_d[511:480] | 32'h8000_0001;
                                end else begin
                                    buf_d[{pad_pos_s[3:0], 5'd0} +: 32] =
                                        buf_d[{pad_pos_s[3:0], 5'd0} +: 32] | 32'h0000_0001;
                                    buf_d[511:480] = buf_d[511:480] | 32'h8000_0000;
                                end
                            end else begin
                                pad_pending_d = 1'b0;
                            end
`endif
                        end else begin
                            state_d = ST_FILL;
                        end
                    end
                end else begin
                    state_d = ST_FILL;
                end
            end

            ST_SEND: begin
                if (out_ready) begin
                    buf_d      = 512'd0;
                    mask_d     = 16'd0;
                    out_last_d = 1'b0;
`ifdef KECCAK_GATHER_PAD_EN
                    if (pad_pending_q) begin
                        // Pad block is loaded in the handshake edge so
                        // out_valid stays high without a gap.
                        state_d       = ST_PAD;
                        buf_d         = PAD_BLOCK;
                        out_last_d    = 1'b1;
                        pad_pending_d = 1'b0;
                    end else begin
                        state_d = ST_FILL;
                    end
`else
                    state_d = ST_FILL;
`endif
                end else begin
                    state_d = ST_SEND;
                end
            end

`ifdef KECCAK_GATHER_PAD_EN
            ST_PAD: begin
                if (out_ready) begin
                    buf_d      = 512'd0;
                    out_last_d = 1'b0;
                    state_d    = ST_FILL;
                end else begin
                    state_d = ST_PAD;
                end
            end
`endif

            default: begin
                state_d       = ST_FILL;
                buf_d         = 512'd0;
                mask_d        = 16'd0;
                pad_pending_d = 1'b0;
                out_last_d    = 1'b0;
            end
        endcase

        out_valid_d = (state_d != ST_FILL);
        stall_d     = (state_d != ST_FILL);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= ST_FILL;
            buf_q         <= 512'd0;
            mask_q        <= 16'd0;
            pad_pending_q <= 1'b0;
            out_last_q    <= 1'b0;
            out_valid_q   <= 1'b0;
            stall_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            buf_q         <= buf_d;
            mask_q        <= mask_d;
            pad_pending_q <= pad_pending_d;
            out_last_q    <= out_last_d;
            out_valid_q   <= out_valid_d;
            stall_q       <= stall_d;
        end
    end

    assign out512    = buf_q;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign stall     = stall_q;

endmodule

// File: tb/tb_keccak_gather.sv
// -----------------------------------------------------------------------------
// tb_keccak_gather
//
// Self-checking bench for keccak_gather. A transaction-level model (word array
// plus a queue of finished blocks) predicts the outputs every cycle; directed
// sequences add hand-computed literal expectations.
// Build option KECCAK_GATHER_PAD_EN is honoured by both model and directed
// expectations.
// -----------------------------------------------------------------------------
module tb_keccak_gather;

    logic         clk;
    logic         reset;
    logic         en;
    logic [5:0]   num;
    logic [31:0]  in32;
    logic [511:0] out512;
    logic         out_valid;
    logic         out_last;
    logic         out_ready;
    logic         stall;

    int n_checks;
    int n_fail;

    keccak_gather dut (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .num       (num),
        .in32      (in32),
        .out512    (out512),
        .out_valid (out_valid),
        .out_last  (out_last),
        .out_ready (out_ready),
        .stall     (stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- model ----------------
    logic [31:0]  m_words [16];
    bit           m_written [16];
    logic [511:0] m_blk_q [$];
    bit           m_last_q [$];

    function automatic logic [511:0] m_pack();
        logic [511:0] r;
        r = 512'd0;
        for (int i = 0; i < 16; i++) r[32*i +: 32] = m_words[i];
        return r;
    endfunction

    task automatic m_clear_words();
        for (int i = 0; i < 16; i++) begin
            m_words[i]   = 32'd0;
            m_written[i] = 1'b0;
        end
    endtask

    task automatic model_step();
        bit all_w;
        bit lst;
        bit extra;
        int hi;
        int k;
        logic [511:0] padblk;
        if (!reset) begin
            m_clear_words();
            m_blk_q.delete();
            m_last_q.delete();
        end else if (m_blk_q.size() > 0) begin
            if (out_ready) begin
                void'(m_blk_q.pop_front());
                void'(m_last_q.pop_front());
            end
        end else if (en) begin
            if (num[5]) begin
                m_clear_words();
            end else begin
                m_words[num[3:0]]   = in32;
                m_written[num[3:0]] = 1'b1;
                all_w = 1'b1;
                for (int i = 0; i < 16; i++) all_w = all_w & m_written[i];
                if (all_w || num[4]) begin
                    lst   = num[4];
                    extra = 1'b0;
`ifdef KECCAK_GATHER_PAD_EN
                    if (num[4]) begin
                        hi = -1;
                        for (int i = 0; i < 16; i++) if (m_written[i]) hi = i;
                        k = hi + 1;
                        if (k < 15) begin
                            m_words[k]  = m_words[k] | 32'h0000_0001;
                            m_words[15] = m_words[15] | 32'h8000_0000;
                        end else if (k == 15) begin
                            m_words[15] = m_words[15] | 32'h8000_0001;
                        end else begin
                            lst   = 1'b0;
                            extra = 1'b1;
                        end
                    end
`endif
                    m_blk_q.push_back(m_pack());
                    m_last_q.push_back(lst);
                    if (extra) begin
                        padblk = 512'd0;
                        padblk[31:0]    = 32'h0000_0001;
                        padblk[511:480] = 32'h8000_0000;
                        m_blk_q.push_back(padblk);
                        m_last_q.push_back(1'b1);
                    end
                    m_clear_words();
                end
            end
        end
    endtask

    initial begin
        m_clear_words();
        forever begin
            @(posedge clk);
            model_step();
        end
    end

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Per-cycle compare against the model, away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            if (!reset) begin
                check("rst_out512", out512, 512'd0);
                check("rst_valid", {511'd0, out_valid}, 512'd0);
                check("rst_last", {511'd0, out_last}, 512'd0);
                check("rst_stall", {511'd0, stall}, 512'd0);
            end else if (m_blk_q.size() > 0) begin
                check("mdl_out512", out512, m_blk_q[0]);
                check("mdl_valid", {511'd0, out_valid}, 512'd1);
                check("mdl_stall", {511'd0, stall}, 512'd1);
                check("mdl_last", {511'd0, out_last}, {511'd0, m_last_q[0]});
            end else begin
                check("mdl_fill512", out512, m_pack());
                check("mdl_valid", {511'd0, out_valid}, 512'd0);
                check("mdl_stall", {511'd0, stall}, 512'd0);
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [5:0] n, input logic [31:0] d);
        en   = 1'b1;
        num  = n;
        in32 = d;
        tick();
        en   = 1'b0;
        num  = 6'd0;
        in32 = 32'd0;
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    logic [511:0] e;

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        reset     = 1'b0;
        en        = 1'b0;
        num       = 6'd0;
        in32      = 32'd0;
        out_ready = 1'b0;
        tick();
        tick();
        check("reset_out512", out512, 512'd0);
        check("reset_valid", {511'd0, out_valid}, 512'd0);
        check("reset_stall", {511'd0, stall}, 512'd0);
        reset = 1'b1;
        tick();

        // Full 16-word fill, out_ready low.
        for (int i = 0; i < 16; i++) begin
            wr({2'b00, 4'(i)}, 32'h1000_0000 + 32'(i));
            if (i == 14) check("valid_before_16th", {511'd0, out_valid}, 512'd0);
        end
        check("full_valid", {511'd0, out_valid}, 512'd1);
        check("full_word0", {480'd0, out512[31:0]}, {480'd0, 32'h1000_0000});
        check("full_word15", {480'd0, out512[511:480]}, {480'd0, 32'h1000_000F});
        tick();
        tick();
        check("full_stall_hold", {511'd0, stall}, 512'd1);
        check("full_last_hold", {511'd0, out_last}, 512'd0);
        check("full_valid_hold", {511'd0, out_valid}, 512'd1);
        handshake();
        check("after_hs_valid", {511'd0, out_valid}, 512'd0);
        check("after_hs_stall", {511'd0, stall}, 512'd0);

        // Partial block closed by num[4] at index 3.
        wr(6'b010011, 32'hAAAA_5555);
        e = 512'd0;
        e[127:96] = 32'hAAAA_5555;
`ifdef KECCAK_GATHER_PAD_EN
        e[159:128] = 32'h0000_0001;
        e[511:480] = 32'h8000_0000;
`endif
        check("partial_block", out512, e);
        check("partial_last", {511'd0, out_last}, 512'd1);
        // Write during SEND is ignored.
        wr(6'd5, 32'hDEAD_BEEF);
        check("send_ignore", out512, e);
        handshake();
        wr(6'd5, 32'hDEAD_BEEF);
        check("reissue_lands", {480'd0, out512[191:160]}, {480'd0, 32'hDEAD_BEEF});
        check("reissue_novalid", {511'd0, out_valid}, 512'd0);

        // Clear with data present, then a fresh full fill.
        for (int i = 0; i < 6; i++) wr({2'b00, 4'(i)}, 32'h3000_0000 + 32'(i));
        wr(6'b100111, 32'h5555_5555);
        check("clear_buf", out512, 512'd0);
        check("clear_novalid", {511'd0, out_valid}, 512'd0);
        for (int i = 0; i < 16; i++) wr({2'b00, 4'(i)}, 32'h2000_0000 + 32'(i));
        e = 512'd0;
        for (int i = 0; i < 16; i++) e[32*i +: 32] = 32'h2000_0000 + 32'(i);
        check("fresh_block", out512, e);
        check("fresh_valid", {511'd0, out_valid}, 512'd1);
        handshake();

        // Final word in slot 15 with out_ready tied high.
        out_ready = 1'b1;
        for (int i = 0; i < 15; i++) wr({2'b00, 4'(i)}, 32'h4000_0000 + 32'(i));
        wr(6'b011111, 32'h4000_000F);
        check("last16_valid", {511'd0, out_valid}, 512'd1);
        check("last16_word15", {480'd0, out512[511:480]}, {480'd0, 32'h4000_000F});
`ifdef KECCAK_GATHER_PAD_EN
        check("last16_last", {511'd0, out_last}, 512'd0);
        tick();
        e = 512'd0;
        e[31:0]    = 32'h0000_0001;
        e[511:480] = 32'h8000_0000;
        check("padblk_data", out512, e);
        check("padblk_valid", {511'd0, out_valid}, 512'd1);
        check("padblk_last", {511'd0, out_last}, 512'd1);
        tick();
        check("padblk_done", {511'd0, out_valid}, 512'd0);
        // k = 15: both pad bits share word 15.
        wr(6'b011110, 32'h0000_00EE);
        check("k15_word15", {480'd0, out512[511:480]}, {480'd0, 32'h8000_0001});
        check("k15_word14", {480'd0, out512[479:448]}, {480'd0, 32'h0000_00EE});
        tick();
`else
        check("last16_last", {511'd0, out_last}, 512'd1);
        tick();
        check("last16_done", {511'd0, out_valid}, 512'd0);
`endif
        out_ready = 1'b0;

        // Reset in the middle of SEND.
        wr(6'b010000, 32'h1234_5678);
        check("pre_reset_valid", {511'd0, out_valid}, 512'd1);
        #2;
        reset = 1'b0;
        #1;
        check("midrst_valid", {511'd0, out_valid}, 512'd0);
        check("midrst_out512", out512, 512'd0);
        check("midrst_stall", {511'd0, stall}, 512'd0);
        check("midrst_last", {511'd0, out_last}, 512'd0);
        tick();
        tick();
        reset = 1'b1;
        tick();
        wr(6'd2, 32'hCAFE_F00D);
        check("post_reset_write", {480'd0, out512[95:64]}, {480'd0, 32'hCAFE_F00D});
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
